// File: rtl/draw_rect_multi.sv
// Rectangle overlay stage for the VGA pipeline.
// Draws up to NUM_OBJ solid rectangles over the incoming pixel stream. Object 0 has
// the highest priority. Positions and enables are shadowed and reloaded only at the
// rising edge of vertical blank. Objects can blink; the phase flips every
// BLINK_FRAMES frames.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-low reset
//   *count_in/sync/blnk  incoming timing; *_out is the same timing delayed 2 clocks
//   rgb_in / rgb_out     background pixel in, composited pixel out (2-clock latency)
//   x_pos, y_pos         packed 12-bit left/top edge per object (shadowed)
//   obj_en               per-object draw enable (shadowed)
//   blink_en             per-object blink enable (used live)
//   frame_tick           one-cycle pulse per shadow reload, aligned with the pixel outputs
module draw_rect_multi #(
    parameter int unsigned           NUM_OBJ      = 4,
    parameter int unsigned           WIDTH        = 60,
    parameter int unsigned           HEIGHT       = 60,
    parameter logic [12*NUM_OBJ-1:0] COLORS       = {NUM_OBJ{12'h01c}},
    parameter int unsigned           BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [10:0]           vcount_in,
    input  logic                  vsync_in,
    input  logic                  vblnk_in,
    input  logic [10:0]           hcount_in,
    input  logic                  hsync_in,
    input  logic                  hblnk_in,
    input  logic [11:0]           rgb_in,
    input  logic [12*NUM_OBJ-1:0] x_pos,
    input  logic [12*NUM_OBJ-1:0] y_pos,
    input  logic [NUM_OBJ-1:0]    obj_en,
    input  logic [NUM_OBJ-1:0]    blink_en,
    output logic [10:0]           vcount_out,
    output logic                  vsync_out,
    output logic                  vblnk_out,
    output logic [10:0]           hcount_out,
    output logic                  hsync_out,
    output logic                  hblnk_out,
    output logic [11:0]           rgb_out,
    output logic                  frame_tick
);

    localparam int unsigned      CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // Shadow registers and frame state
    logic [12*NUM_OBJ-1:0] x_s;
    logic [12*NUM_OBJ-1:0] y_s;
    logic [NUM_OBJ-1:0]    en_s;
    logic [CNT_W-1:0]      frame_cnt;
    logic                  blink_phase;
    logic                  vblnk_prev;
    logic                  update;

    // Stage 1
    logic [NUM_OBJ-1:0] vis;
    logic [NUM_OBJ-1:0] vis_s1;
    logic [11:0]        rgb_s1;
    logic               blank_s1;
    logic [10:0]        vcount_s1;
    logic [10:0]        hcount_s1;
    logic               vsync_s1;
    logic               vblnk_s1;
    logic               hsync_s1;
    logic               hblnk_s1;
    logic               tick_s1;

    logic [11:0]        rgb_next;

    assign update = vblnk_in & ~vblnk_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_s         <= '0;
            y_s         <= '0;
            en_s        <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            vblnk_prev  <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (update) begin
                x_s  <= x_pos;
                y_s  <= y_pos;
                en_s <= obj_en;
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Bounds are compared at 13 bits so x+WIDTH past 4095 clips instead of wrapping.
    always_comb begin
        vis = '0;
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            vis[i] = en_s[i]
                & ({2'b00, hcount_in} >= {1'b0, x_s[12*i +: 12]})
                & ({2'b00, hcount_in} <  ({1'b0, x_s[12*i +: 12]} + 13'(WIDTH)))
                & ({2'b00, vcount_in} >= {1'b0, y_s[12*i +: 12]})
                & ({2'b00, vcount_in} <  ({1'b0, y_s[12*i +: 12]} + 13'(HEIGHT)))
                & ~(blink_en[i] & blink_phase);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vis_s1    <= '0;
            rgb_s1    <= '0;
            blank_s1  <= 1'b0;
            vcount_s1 <= '0;
            hcount_s1 <= '0;
            vsync_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            hsync_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            tick_s1   <= 1'b0;
        end else begin
            vis_s1    <= vis;
            rgb_s1    <= rgb_in;
            blank_s1  <= vblnk_in | hblnk_in;
            vcount_s1 <= vcount_in;
            hcount_s1 <= hcount_in;
            vsync_s1  <= vsync_in;
            vblnk_s1  <= vblnk_in;
            hsync_s1  <= hsync_in;
            hblnk_s1  <= hblnk_in;
            tick_s1   <= update;
        end
    end

    // Walk from the highest index down so the lowest set index wins.
    always_comb begin
        rgb_next = rgb_s1;
        for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
            if (vis_s1[i]) begin
                rgb_next = COLORS[12*i +: 12];
            end
        end
        if (blank_s1) begin
            rgb_next = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            vcount_out <= vcount_s1;
            vsync_out  <= vsync_s1;
            vblnk_out  <= vblnk_s1;
            hcount_out <= hcount_s1;
            hsync_out  <= hsync_s1;
            hblnk_out  <= hblnk_s1;
            rgb_out    <= rgb_next;
            frame_tick <= tick_s1;
        end
    end

endmodule

// File: tb/tb_draw_rect_multi.sv
// Bench for draw_rect_multi: behavioural model checked on every falling edge, plus
// directed literal checks for positions, priority, shadowing, blinking, clipping and reset.
module tb_draw_rect_multi;

    localparam int NUM_OBJ = 4;
    localparam int WIDTH   = 60;
    localparam int HEIGHT  = 60;
    localparam int BF      = 2;
    localparam logic [12*NUM_OBJ-1:0] COLORS = {12'h777, 12'h0a5, 12'hf00, 12'h01c};

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [10:0]           vcount_in = '0;
    logic                  vsync_in = 1'b0;
    logic                  vblnk_in = 1'b0;
    logic [10:0]           hcount_in = '0;
    logic                  hsync_in = 1'b0;
    logic                  hblnk_in = 1'b0;
    logic [11:0]           rgb_in = '0;
    logic [12*NUM_OBJ-1:0] x_pos = '0;
    logic [12*NUM_OBJ-1:0] y_pos = '0;
    logic [NUM_OBJ-1:0]    obj_en = '0;
    logic [NUM_OBJ-1:0]    blink_en = '0;
    logic [10:0]           vcount_out;
    logic                  vsync_out;
    logic                  vblnk_out;
    logic [10:0]           hcount_out;
    logic                  hsync_out;
    logic                  hblnk_out;
    logic [11:0]           rgb_out;
    logic                  frame_tick;

    draw_rect_multi #(
        .NUM_OBJ      (NUM_OBJ),
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .COLORS       (COLORS),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vcount_in  (vcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .hcount_in  (hcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .rgb_in     (rgb_in),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .obj_en     (obj_en),
        .blink_en   (blink_en),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .rgb_out    (rgb_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    typedef struct packed {
        logic [10:0] vc;
        logic        vs;
        logic        vb;
        logic [10:0] hc;
        logic        hs;
        logic        hb;
        logic [11:0] rgb;
        logic        tick;
    } out_t;

    // Model state: what the screen should look like, from the rules alone.
    out_t s1, s2, nw, act;
    int   mx [NUM_OBJ];
    int   my [NUM_OBJ];
    bit   men[NUM_OBJ];
    bit   mprev;
    int   nupd;

    function automatic bit model_visible(input int i, input int h, input int v);
        bit phase;
        phase = ((nupd / BF) % 2) == 1;
        return men[i] && h >= mx[i] && h < mx[i] + WIDTH && v >= my[i] && v < my[i] + HEIGHT
               && !(blink_en[i] && phase);
    endfunction

    always @(negedge clk) begin
        bit upd;
        if (!rst) begin
            s1 = '0;
            s2 = '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                mx[i] = 0; my[i] = 0; men[i] = 1'b0;
            end
            mprev = 1'b0;
            nupd  = 0;
        end
        act = {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out,
               rgb_out, frame_tick};
        checks++;
        if (act !== s2) begin
            errors++;
            $display("FAIL model t=%0t got %h want %h", $time, act, s2);
        end
        if (frame_tick === 1'b1) ticks++;
        if (rst) begin
            upd     = vblnk_in && !mprev;
            nw.vc   = vcount_in;
            nw.vs   = vsync_in;
            nw.vb   = vblnk_in;
            nw.hc   = hcount_in;
            nw.hs   = hsync_in;
            nw.hb   = hblnk_in;
            nw.tick = upd;
            if (vblnk_in || hblnk_in) begin
                nw.rgb = 12'h000;
            end else begin
                nw.rgb = rgb_in;
                for (int i = NUM_OBJ - 1; i >= 0; i--)
                    if (model_visible(i, int'(hcount_in), int'(vcount_in)))
                        nw.rgb = COLORS[12*i +: 12];
            end
            s2 = s1;
            s1 = nw;
            if (upd) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    mx[i]  = int'(x_pos[12*i +: 12]);
                    my[i]  = int'(y_pos[12*i +: 12]);
                    men[i] = obj_en[i];
                end
                nupd++;
            end
            mprev = vblnk_in;
        end
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic [11:0] c);
        @(posedge clk);
        #1;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = c;
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 400), $urandom_range(0, 300), $urandom_range(0, 15) == 0, 1'b0,
              12'($urandom));
    endtask

    task automatic vblank(input int len);
        for (int k = 0; k < len; k++)
            drive($urandom_range(0, 400), $urandom_range(0, 300), 1'b0, 1'b1, 12'($urandom));
        repeat (3) drive_rand();
    endtask

    // Drive one pixel and look at rgb_out two clocks later.
    task automatic peek(input string name, input int h, input int v, input logic hb,
                        input logic [11:0] c, input logic [11:0] want);
        drive(h, v, hb, 1'b0, c);
        drive_rand();
        @(posedge clk);
        #1;
        check_lit(name, 32'(rgb_out), 32'(want));
    endtask

    task automatic set_obj(input int i, input int x, input int y);
        x_pos[12*i +: 12] = 12'(x);
        y_pos[12*i +: 12] = 12'(y);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        bit pat[8] = '{1, 0, 0, 1, 1, 0, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_outputs",
                  32'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out,
                       rgb_out, frame_tick}), 32'h0);
        #1 rst = 1'b1;
        repeat (4) drive_rand();

        // Nothing drawn before the first update even though inputs request it
        set_obj(0, 100, 50);
        obj_en = 4'b0001;
        peek("pre_update", 110, 60, 1'b0, 12'h123, 12'h123);

        // Single object
        t0 = ticks;
        vblank(5);
        check_lit("one_tick_per_vblank", 32'(ticks - t0), 32'd1);
        peek("obj0_top_left",  100,  50, 1'b0, 12'h456, 12'h01c);
        peek("obj0_bot_right", 159, 109, 1'b0, 12'h456, 12'h01c);
        peek("obj0_right_out", 160,  50, 1'b0, 12'h456, 12'h456);
        peek("obj0_left_out",   99,  50, 1'b0, 12'h789, 12'h789);
        peek("obj0_below",     120, 110, 1'b0, 12'h789, 12'h789);
        repeat (200) drive($urandom_range(80, 180), $urandom_range(30, 130), 1'b0, 1'b0,
                           12'($urandom));

        // Priority between overlapping objects
        set_obj(0, 100, 100);
        set_obj(1, 130, 130);
        obj_en = 4'b0011;
        vblank(3);
        peek("overlap_obj0_wins", 140, 140, 1'b0, 12'h333, 12'h01c);
        peek("obj1_only",         170, 170, 1'b0, 12'h333, 12'hf00);
        peek("hblnk_in_rect",     110, 110, 1'b1, 12'h333, 12'h000);

        // Mid-frame position change is shadowed until the next vblank
        set_obj(0, 100, 50);
        obj_en = 4'b0001;
        vblank(2);
        peek("pre_change_at_100", 120, 60, 1'b0, 12'h222, 12'h01c);
        set_obj(0, 300, 50);
        peek("mid_change_still_100", 120, 60, 1'b0, 12'h222, 12'h01c);
        peek("mid_change_not_300",   310, 60, 1'b0, 12'h222, 12'h222);
        t0 = ticks;
        vblank(8);
        check_lit("held_vblank_one_tick", 32'(ticks - t0), 32'd1);
        peek("next_frame_at_300", 310, 60, 1'b0, 12'h222, 12'h01c);
        peek("next_frame_not_100", 120, 60, 1'b0, 12'h222, 12'h222);

        // Blink: 2 frames on, 2 frames off; object 1 steady
        do_reset();
        set_obj(0, 100, 50);
        set_obj(1, 300, 50);
        obj_en   = 4'b0011;
        blink_en = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            vblank(2);
            peek($sformatf("blink_obj0_f%0d", k + 1), 110, 60, 1'b0, 12'h0f0,
                 pat[k] ? 12'h01c : 12'h0f0);
            peek($sformatf("steady_obj1_f%0d", k + 1), 310, 60, 1'b0, 12'h0f0, 12'hf00);
        end
        blink_en = '0;

        // Clipping near 4095 must not alias to column 0
        set_obj(0, 4080, 0);
        obj_en = 4'b0001;
        vblank(2);
        for (int h = 0; h < 20; h++) drive(h, 10, 1'b0, 1'b0, 12'($urandom));
        peek("clip_no_wrap_h5", 5, 10, 1'b0, 12'h5a5, 12'h5a5);

        // Asynchronous reset mid-line
        set_obj(0, 100, 50);
        vblank(2);
        drive(110, 60, 1'b0, 1'b0, 12'h111);
        drive(111, 60, 1'b0, 1'b0, 12'h111);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_lit("async_reset_outputs",
                  32'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out,
                       rgb_out, frame_tick}), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        peek("after_reset_nothing", 110, 60, 1'b0, 12'h444, 12'h444);
        vblank(2);
        peek("after_reset_update", 110, 60, 1'b0, 12'h444, 12'h01c);

        // Randomized frames against the model
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if ($urandom_range(0, 7) == 0) set_obj(i, $urandom_range(3990, 4095), $urandom_range(0, 250));
                else set_obj(i, $urandom_range(0, 350), $urandom_range(0, 250));
            end
            obj_en   = 4'($urandom);
            blink_en = 4'($urandom);
            vblank($urandom_range(1, 6));
            for (int p = 0; p < 300; p++) begin
                if (p == 150) begin
                    set_obj($urandom_range(0, NUM_OBJ - 1), $urandom_range(0, 350),
                            $urandom_range(0, 250));
                    obj_en = 4'($urandom);
                end
                drive_rand();
            end
        end
        repeat (4) drive_rand();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
